// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit and the datapath muxes it steers.
// Holds the state set, the MIPS opcode/funct values and the select/ALU codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_WB_R    = 4'd4,
        S_EXEC_I  = 4'd5,
        S_WB_I    = 4'd6,
        S_ADDR    = 4'd7,
        S_MEM_RD  = 4'd8,
        S_WB_LW   = 4'd9,
        S_MEM_WR  = 4'd10,
        S_BRANCH  = 4'd11,
        S_JUMP    = 4'd12,
        S_EXC_OVF = 4'd13,
        S_EXC_OPC = 4'd14
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;

    localparam logic [2:0] ALU_NOP  = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_write;
        logic       mdr_write;
        logic       ab_write;
        logic       alu_out_write;
        logic       reg_write;
        logic       iord;
        logic       alu_src_a;
        logic       mem_to_reg;
        logic       reg_dst;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
        logic       exc_ovf;
        logic       exc_opc;
    } ctrl_out_t;

    // ALU_NOP doubles as "unsupported R-type funct".
    function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
        logic [2:0] op;
        case (fn)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS-subset control FSM; all datapath selects and write enables are
// decoded from the registered state and wait counter only.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   RESET     | all outputs idle, go fetch
//   FETCH     | read instr, PC+4; IR/PC written on last wait count
//   DECODE    | load A/B, precompute branch target, dispatch
//   EXEC_R    | R-type ALU op (add/sub/and)
//   WB_R      | write ALUOut to rd
//   EXEC_I    | addi ALU op
//   WB_I      | write ALUOut to rt
//   ADDR      | effective address for lw/sw
//   MEM_RD    | data read; MDR written on last wait count
//   WB_LW     | write MDR to rt
//   MEM_WR    | single-cycle store
//   BRANCH    | beq compare, conditional PC write
//   JUMP      | PC <= jump target
//   EXC_OVF   | arithmetic overflow pulse
//   EXC_OPC   | illegal opcode/funct pulse
module control_unit_fsm #(
    parameter int MEM_WAIT = 1   // 0..7 extra memory cycles
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       mem_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       alu_out_write,
    output logic       reg_write,
    output logic       iord,
    output logic       alu_src_a,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       exc_ovf,
    output logic       exc_opc
);
    import ctrl_pkg::*;

    localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      ralu_q, ralu_d;
    logic            wait_done;
    ctrl_out_t       out;

    // The branch outcome is resolved in the datapath, not here.
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_done = (cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            cnt_q   <= '0;
            ralu_q  <= ALU_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ralu_q  <= ralu_d;
        end
    end

    // Counter is zero in every state except while counting, so it is cleared on entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        ralu_d  = ralu_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (wait_done) state_d = S_DECODE;
                else           cnt_d   = cnt_q + 1'b1;
            end
            S_DECODE: begin
                ralu_d = rtype_alu_op(funct);
                case (opcode)
                    OP_RTYPE: state_d = (rtype_alu_op(funct) != ALU_NOP) ? S_EXEC_R : S_EXC_OPC;
                    OP_ADDI:  state_d = S_EXEC_I;
                    OP_LW:    state_d = S_ADDR;
                    OP_SW:    state_d = S_ADDR;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_J:     state_d = S_JUMP;
                    default:  state_d = S_EXC_OPC;
                endcase
            end
            S_EXEC_R: state_d = (overflow && (funct != FN_AND)) ? S_EXC_OVF : S_WB_R;
            S_EXEC_I: state_d = overflow ? S_EXC_OVF : S_WB_I;
            S_ADDR:   state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (wait_done) state_d = S_WB_LW;
                else           cnt_d   = cnt_q + 1'b1;
            end
            S_WB_R, S_WB_I, S_WB_LW, S_MEM_WR, S_BRANCH, S_JUMP,
            S_EXC_OVF, S_EXC_OPC: state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        out = '0;
        case (state_q)
            S_FETCH: begin
                out.alu_src_b = SRCB_FOUR;
                out.alu_op    = ALU_ADD;
                out.pc_source = PCSRC_ALU;
                out.ir_write  = wait_done;
                out.pc_write  = wait_done;
            end
            S_DECODE: begin
                out.alu_src_b     = SRCB_IMM_SH;
                out.alu_op        = ALU_ADD;
                out.alu_out_write = 1'b1;
                out.ab_write      = 1'b1;
            end
            S_EXEC_R: begin
                out.alu_src_a     = 1'b1;
                out.alu_src_b     = SRCB_B;
                out.alu_op        = ralu_q;
                out.alu_out_write = 1'b1;
            end
            S_WB_R: begin
                out.reg_dst   = 1'b1;
                out.reg_write = 1'b1;
            end
            S_EXEC_I, S_ADDR: begin
                out.alu_src_a     = 1'b1;
                out.alu_src_b     = SRCB_IMM;
                out.alu_op        = ALU_ADD;
                out.alu_out_write = 1'b1;
            end
            S_WB_I:   out.reg_write = 1'b1;
            S_MEM_RD: begin
                out.iord      = 1'b1;
                out.mdr_write = wait_done;
            end
            S_WB_LW: begin
                out.mem_to_reg = 1'b1;
                out.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                out.iord      = 1'b1;
                out.mem_write = 1'b1;
            end
            S_BRANCH: begin
                out.alu_src_a     = 1'b1;
                out.alu_src_b     = SRCB_B;
                out.alu_op        = ALU_SUB;
                out.pc_write_cond = 1'b1;
                out.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                out.pc_source = PCSRC_JUMP;
                out.pc_write  = 1'b1;
            end
            S_EXC_OVF: out.exc_ovf = 1'b1;
            S_EXC_OPC: out.exc_opc = 1'b1;
            default:   out = '0;
        endcase
    end

    assign pc_write      = out.pc_write;
    assign pc_write_cond = out.pc_write_cond;
    assign ir_write      = out.ir_write;
    assign mem_write     = out.mem_write;
    assign mdr_write     = out.mdr_write;
    assign ab_write      = out.ab_write;
    assign alu_out_write = out.alu_out_write;
    assign reg_write     = out.reg_write;
    assign iord          = out.iord;
    assign alu_src_a     = out.alu_src_a;
    assign mem_to_reg    = out.mem_to_reg;
    assign reg_dst       = out.reg_dst;
    assign alu_src_b     = out.alu_src_b;
    assign pc_source     = out.pc_source;
    assign alu_op        = out.alu_op;
    assign exc_ovf       = out.exc_ovf;
    assign exc_opc       = out.exc_opc;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Scoreboard bench for control_unit_fsm: an instruction-level model queues the
// expected per-cycle control vectors, a negedge monitor pops and compares them.
module tb_control_unit_fsm;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       overflow = 1'b0;
    logic       pc_write, pc_write_cond, ir_write, mem_write, mdr_write, ab_write;
    logic       alu_out_write, reg_write, iord, alu_src_a, mem_to_reg, reg_dst;
    logic [1:0] alu_src_b, pc_source;
    logic [2:0] alu_op;
    logic       exc_ovf, exc_opc;

    always #5 clk = ~clk;

    control_unit_fsm #(.MEM_WAIT(W)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .overflow(overflow),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_write(mem_write), .mdr_write(mdr_write), .ab_write(ab_write),
        .alu_out_write(alu_out_write), .reg_write(reg_write), .iord(iord),
        .alu_src_a(alu_src_a), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .alu_src_b(alu_src_b), .pc_source(pc_source), .alu_op(alu_op),
        .exc_ovf(exc_ovf), .exc_opc(exc_opc)
    );

    typedef struct packed {
        logic       pc_write, pc_write_cond, ir_write, mem_write, mdr_write, ab_write;
        logic       alu_out_write, reg_write, iord, alu_src_a, mem_to_reg, reg_dst;
        logic [1:0] alu_src_b, pc_source;
        logic [2:0] alu_op;
        logic       exc_ovf, exc_opc;
    } outv_t;

    typedef struct {
        outv_t v;
        string tag;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  seq[$];
    int    n_checks = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;
    outv_t act;
    exp_t  mon_e;

    always_comb begin
        act = '0;
        act.pc_write = pc_write;         act.pc_write_cond = pc_write_cond;
        act.ir_write = ir_write;         act.mem_write = mem_write;
        act.mdr_write = mdr_write;       act.ab_write = ab_write;
        act.alu_out_write = alu_out_write; act.reg_write = reg_write;
        act.iord = iord;                 act.alu_src_a = alu_src_a;
        act.mem_to_reg = mem_to_reg;     act.reg_dst = reg_dst;
        act.alu_src_b = alu_src_b;       act.pc_source = pc_source;
        act.alu_op = alu_op;             act.exc_ovf = exc_ovf;
        act.exc_opc = exc_opc;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL underflow: DUT cycle with no expectation queued (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (act !== mon_e.v) begin
                    n_fail++;
                    $display("FAIL %s: got %h required %h (t=%0t)", mon_e.tag, act, mon_e.v, $time);
                end
            end
        end
    end

    task automatic add(input outv_t v, input string tag);
        exp_t e;
        e.v = v;
        e.tag = tag;
        seq.push_back(e);
    endtask

    // Expected control vectors for one instruction, cycle by cycle, from the state rules.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic ovf);
        outv_t v;
        bit    rtype_ok;
        seq.delete();
        for (int c = 0; c <= W; c++) begin
            v = '0; v.alu_src_b = 2'b01; v.alu_op = 3'b001;
            v.ir_write = (c == W); v.pc_write = (c == W);
            add(v, "FETCH");
        end
        v = '0; v.alu_src_b = 2'b11; v.alu_op = 3'b001; v.alu_out_write = 1'b1; v.ab_write = 1'b1;
        add(v, "DECODE");
        rtype_ok = (op == 6'h00) && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24);
        if (rtype_ok) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_out_write = 1'b1;
            v.alu_op = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
            add(v, "EXEC_R");
            if (ovf && fn != 6'h24) begin
                v = '0; v.exc_ovf = 1'b1; add(v, "EXC_OVF");
            end else begin
                v = '0; v.reg_dst = 1'b1; v.reg_write = 1'b1; add(v, "WB_R");
            end
        end else if (op == 6'h08) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 3'b001; v.alu_out_write = 1'b1;
            add(v, "EXEC_I");
            if (ovf) begin
                v = '0; v.exc_ovf = 1'b1; add(v, "EXC_OVF");
            end else begin
                v = '0; v.reg_write = 1'b1; add(v, "WB_I");
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 3'b001; v.alu_out_write = 1'b1;
            add(v, "ADDR");
            if (op == 6'h23) begin
                for (int c = 0; c <= W; c++) begin
                    v = '0; v.iord = 1'b1; v.mdr_write = (c == W); add(v, "MEM_RD");
                end
                v = '0; v.mem_to_reg = 1'b1; v.reg_write = 1'b1; add(v, "WB_LW");
            end else begin
                v = '0; v.iord = 1'b1; v.mem_write = 1'b1; add(v, "MEM_WR");
            end
        end else if (op == 6'h04) begin
            v = '0; v.alu_src_a = 1'b1; v.alu_op = 3'b010; v.pc_write_cond = 1'b1; v.pc_source = 2'b01;
            add(v, "BRANCH");
        end else if (op == 6'h02) begin
            v = '0; v.pc_source = 2'b10; v.pc_write = 1'b1; add(v, "JUMP");
        end else begin
            v = '0; v.exc_opc = 1'b1; add(v, "EXC_OPC");
        end
    endtask

    // Called one step after a clock edge; holds reset for n edges, returns in the first FETCH cycle.
    task automatic apply_reset(input int n);
        exp_t e;
        e.v = '0;
        e.tag = "RESET";
        reset = 1'b1;
        for (int k = 0; k < n; k++) exp_q.push_back(e);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // cut = 0: whole instruction; cut > 0: reset lands after that many cycles; cut < 0: random cut.
    task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic ovf, input int cut);
        int n;
        bit cutting;
        build(op, fn, ovf);
        if (cut < 0) cut = $urandom_range(1, seq.size() - 1);
        cutting = (cut > 0) && (cut < seq.size());
        n = cutting ? cut : seq.size();
        for (int i = 0; i < n; i++) exp_q.push_back(seq[i]);
        for (int i = 0; i < n; i++) begin
            // IR is only valid from DECODE on; junk before that must not matter.
            if (i <= W) begin
                opcode = 6'($urandom); funct = 6'($urandom); overflow = 1'($urandom);
            end else begin
                opcode = op; funct = fn; overflow = ovf;
            end
            zero = 1'($urandom);
            if (i < n - 1 || !cutting) begin
                @(posedge clk); #1;
            end
        end
        if (cutting) apply_reset($urandom_range(1, 3));
    endtask

    task automatic run_random();
        logic [5:0] op, fn;
        logic       ovf;
        int         sel;
        sel = $urandom_range(0, 9);
        ovf = 1'($urandom);
        fn  = 6'($urandom);
        op  = 6'h00;
        case (sel)
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: op = 6'h00;
            4: op = 6'h08;
            5: op = 6'h23;
            6: op = 6'h2B;
            7: op = 6'h04;
            8: op = 6'h02;
            default: op = 6'($urandom);
        endcase
        run(op, fn, ovf, ($urandom_range(0, 7) == 0) ? -1 : 0);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back('{v: '0, tag: "RESET"});
        mon_en = 1'b1;
        apply_reset(2);

        run(6'h23, 6'h00, 1'b0, 2);          // reset at FETCH count 1
        run(6'h00, 6'h20, 1'b0, 0);          // add
        run(6'h00, 6'h22, 1'b1, 0);          // sub overflow
        run(6'h00, 6'h24, 1'b1, 0);          // and ignores overflow
        run(6'h08, 6'h11, 1'b1, 0);          // addi overflow
        run(6'h08, 6'h11, 1'b0, 0);
        run(6'h23, 6'h05, 1'b1, 0);          // lw, overflow ignored in ADDR
        run(6'h2B, 6'h05, 1'b0, 0);
        run(6'h04, 6'h00, 1'b0, 0);
        run(6'h02, 6'h00, 1'b1, 0);
        run(6'h3F, 6'h20, 1'b0, 0);          // illegal opcode
        run(6'h00, 6'h27, 1'b0, 0);          // illegal funct
        run(6'h23, 6'h00, 1'b0, W + 5);      // reset mid MEM_RD
        run(6'h23, 6'h00, 1'b0, 2 * W + 4);  // reset on final MEM_RD count
        for (int i = 0; i < 250; i++) run_random();

        mon_en = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
